// File: rtl/fft32_pkg.sv
// fft32_pkg: shared constants for the 32-point FFT datapath.
//   FRAME_LEN  samples per frame (power of two)
//   NUM_DEST   number of stage buffers fed by the demux
//   SEL_WIDTH  destination selector width
//   dest_e     destination encodings DEST_STAGE0..DEST_STAGE4 = 0..4
package fft32_pkg;
    localparam int FRAME_LEN = 32;
    localparam int NUM_DEST  = 5;
    localparam int SEL_WIDTH = 3;

    typedef enum logic [SEL_WIDTH-1:0] {
        DEST_STAGE0 = 3'd0,
        DEST_STAGE1 = 3'd1,
        DEST_STAGE2 = 3'd2,
        DEST_STAGE3 = 3'd3,
        DEST_STAGE4 = 3'd4
    } dest_e;
endpackage

// File: rtl/fft32_demux1x5_if.sv
// fft32_demux1x5_if: stream bus of the 1-to-5 frame demux.
//   in_data/in_valid/in_ready  input sample handshake
//   dest_sel                   destination for the frame (first sample only)
//   out_data                   shared data bus to all destinations
//   out_valid/out_ready        one-hot per-destination handshake
//   cur_dest, frame_done, err  status
// slave = demux side, master = source/sink side.
interface fft32_demux1x5_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 3,
    parameter int NUM_DEST   = 5
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [SEL_WIDTH-1:0]  dest_sel;
    logic [DATA_WIDTH-1:0] out_data;
    logic [NUM_DEST-1:0]   out_valid;
    logic [NUM_DEST-1:0]   out_ready;
    logic [SEL_WIDTH-1:0]  cur_dest;
    logic                  frame_done;
    logic                  err;

    modport slave (
        input  in_data, in_valid, dest_sel, out_ready,
        output in_ready, out_data, out_valid, cur_dest, frame_done, err
    );

    modport master (
        output in_data, in_valid, dest_sel, out_ready,
        input  in_ready, out_data, out_valid, cur_dest, frame_done, err
    );
endinterface

// File: rtl/fft32_pipe_reg.sv
// fft32_pipe_reg: one-entry output register holding {data, tag}.
//   clk, rst   clock, asynchronous active-high reset
//   load_i     capture data_i/tag_i (wins over drain, so drain+load reloads)
//   drain_i    held entry consumed this cycle
//   data_i/tag_i  entry to capture
//   full_o/data_o/tag_o  held entry
module fft32_pipe_reg #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  drain_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [TAG_WIDTH-1:0]  tag_i,
    output logic                  full_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [TAG_WIDTH-1:0]  tag_o
);
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        tag_d  = tag_q;
        if (load_i) begin
            full_d = 1'b1;
            data_d = data_i;
            tag_d  = tag_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            tag_q  <= tag_d;
        end
    end

    assign full_o = full_q;
    assign data_o = data_q;
    assign tag_o  = tag_q;
endmodule

// File: rtl/fft32_demux1x5.sv
// fft32_demux1x5: frame-based 1-to-5 stream distributor.
//   clk, rst  clock, asynchronous active-high reset
//   bus       fft32_demux1x5_if.slave (sample input, one-hot outputs, status)
// Each FRAME_LEN-sample frame goes to the destination sampled from dest_sel
// on its first sample. Frames with an illegal destination (>= 5) are
// accepted and discarded.
// Optional macro FFT32_DEMUX_ERR_EN: sticky err on an illegal-destination
// frame; otherwise err is tied low.
module fft32_demux1x5 #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_WIDTH  = 3,
    parameter int FRAME_LEN  = 32
) (
    input  logic          clk,
    input  logic          rst,
    fft32_demux1x5_if.slave bus
);
    import fft32_pkg::*;

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]  cur_dest_q, cur_dest_d;
    logic                  frame_done_q, frame_done_d;

    logic                  first, legal, in_ready, accept, load;
    logic                  full, drain;
    logic [SEL_WIDTH-1:0]  frame_sel, tag;
    logic [NUM_DEST-1:0]   tag_onehot;
    logic [DATA_WIDTH-1:0] data;

    always_comb begin
        first     = (cnt_q == '0);
        // The frame's destination is dest_sel only on its first sample.
        frame_sel = first ? bus.dest_sel : cur_dest_q;
        legal     = (frame_sel <= SEL_WIDTH'(DEST_STAGE4));

        tag_onehot = '0;
        for (int unsigned k = 0; k < NUM_DEST; k++) begin
            if (tag == SEL_WIDTH'(k)) tag_onehot[k] = 1'b1;
        end

        // Only the ready bit of the held sample's own destination counts.
        drain    = full && |(tag_onehot & bus.out_ready);
        // Illegal frames are sunk unconditionally, independent of the output.
        in_ready = legal ? (!full || drain) : 1'b1;
        accept   = bus.in_valid && in_ready;
        load     = accept && legal;

        cnt_d        = accept ? cnt_q + 1'b1 : cnt_q;
        cur_dest_d   = (accept && first) ? bus.dest_sel : cur_dest_q;
        frame_done_d = accept && (cnt_q == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            cur_dest_q   <= SEL_WIDTH'(DEST_STAGE0);
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_dest_q   <= cur_dest_d;
            frame_done_q <= frame_done_d;
        end
    end

    fft32_pipe_reg #(
        .DATA_WIDTH(DATA_WIDTH),
        .TAG_WIDTH (SEL_WIDTH)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .drain_i(drain),
        .data_i (bus.in_data),
        .tag_i  (frame_sel),
        .full_o (full),
        .data_o (data),
        .tag_o  (tag)
    );

`ifdef FFT32_DEMUX_ERR_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | (accept && first && !legal);
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready   = in_ready;
    assign bus.out_data   = data;
    assign bus.out_valid  = full ? tag_onehot : '0;
    assign bus.cur_dest   = cur_dest_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_fft32_demux1x5.sv
module tb_fft32_demux1x5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

`ifdef FFT32_DEMUX_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    fft32_demux1x5_if #(.DATA_WIDTH(16), .SEL_WIDTH(3), .NUM_DEST(5)) bus ();

    fft32_demux1x5 #(.DATA_WIDTH(16), .SEL_WIDTH(3), .FRAME_LEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Drive one cycle: inputs after the falling edge, in_ready sampled before
    // the rising edge, return 1 time unit after the rising edge.
    task automatic step(input logic [15:0] d, input logic [2:0] ds, input logic v,
                        input logic [4:0] r, output logic rdy);
        @(negedge clk);
        bus.in_data   = d;
        bus.dest_sel  = ds;
        bus.in_valid  = v;
        bus.out_ready = r;
        #1 rdy = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        logic rdy;
        step(16'h0, 3'd0, 1'b0, 5'b11111, rdy);
    endtask

    task automatic test_reset();
        bus.in_data = '0; bus.dest_sel = '0; bus.in_valid = 1'b0; bus.out_ready = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if ({bus.out_data, bus.out_valid, bus.in_ready, bus.cur_dest, bus.frame_done, bus.err} !==
            {16'h0, 5'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset got data=%h valid=%b rdy=%b dest=%0d fd=%b err=%b", bus.out_data,
                     bus.out_valid, bus.in_ready, bus.cur_dest, bus.frame_done, bus.err);
        end
        total++;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_stream();
        logic rdy;
        for (int i = 0; i < 32; i++) begin
            step(16'(i), 3'd2, 1'b1, 5'b11111, rdy);
            if (bus.out_valid !== 5'b00100 || bus.out_data !== 16'(i)) begin
                bad++;
                $display("FAIL stream_out i=%0d got %b/%h exp 00100/%h", i, bus.out_valid, bus.out_data, 16'(i));
            end
            total++;
            if (bus.frame_done !== (i == 31) || bus.cur_dest !== 3'd2) begin
                bad++;
                $display("FAIL stream_status i=%0d fd=%b dest=%0d exp fd=%b dest=2", i, bus.frame_done, bus.cur_dest, i == 31);
            end
            total++;
        end
        idle();
        if (bus.out_valid !== 5'b0 || bus.frame_done !== 1'b0) begin
            bad++;
            $display("FAIL stream_drain valid=%b fd=%b exp 00000/0", bus.out_valid, bus.frame_done);
        end
        total++;
    endtask

    task automatic test_dest_toggle();
        logic rdy;
        logic [2:0] ds;
        for (int i = 0; i < 64; i++) begin
            if (i < 32) ds = (i % 2 == 0) ? 3'd0 : 3'd3;
            else        ds = (i % 2 == 0) ? 3'd4 : 3'd1;
            step(16'h0200 + 16'(i), ds, 1'b1, 5'b11111, rdy);
            if (bus.out_valid !== ((i < 32) ? 5'b00001 : 5'b10000) || bus.out_data !== 16'h0200 + 16'(i)) begin
                bad++;
                $display("FAIL toggle_out i=%0d got %b/%h", i, bus.out_valid, bus.out_data);
            end
            total++;
            if (bus.cur_dest !== ((i < 32) ? 3'd0 : 3'd4) || bus.frame_done !== (i == 31 || i == 63)) begin
                bad++;
                $display("FAIL toggle_status i=%0d dest=%0d fd=%b", i, bus.cur_dest, bus.frame_done);
            end
            total++;
        end
        idle();
    endtask

    task automatic test_backpressure();
        logic rdy, exp_rdy;
        logic [4:0] r;
        int s = 0;
        int stall = 0;
        while (s < 32) begin
            if (s == 6 && stall < 3) begin
                r = (stall == 1) ? 5'b01000 : 5'b00000;
                exp_rdy = 1'b0;
                stall++;
            end else begin
                r = 5'b00010;
                exp_rdy = 1'b1;
            end
            step(16'h0100 + 16'(s), 3'd1, 1'b1, r, rdy);
            if (rdy !== exp_rdy) begin
                bad++;
                $display("FAIL bp_ready s=%0d got %b exp %b", s, rdy, exp_rdy);
            end
            total++;
            if (bus.out_valid !== 5'b00010 ||
                bus.out_data !== 16'h0100 + 16'(exp_rdy ? s : s - 1)) begin
                bad++;
                $display("FAIL bp_out s=%0d got %b/%h exp 00010/%h", s, bus.out_valid, bus.out_data,
                         16'h0100 + 16'(exp_rdy ? s : s - 1));
            end
            total++;
            if (exp_rdy) s++;
        end
        idle();
    endtask

    task automatic test_stalled_last();
        logic rdy;
        for (int i = 0; i < 32; i++) begin
            step(16'h0300 + 16'(i), 3'd3, 1'b1, 5'b11111, rdy);
            if (bus.out_valid !== 5'b01000 || bus.out_data !== 16'h0300 + 16'(i)) begin
                bad++;
                $display("FAIL last_f1 i=%0d got %b/%h", i, bus.out_valid, bus.out_data);
            end
            total++;
        end
        if (bus.frame_done !== 1'b1) begin
            bad++;
            $display("FAIL last_fd got %b exp 1", bus.frame_done);
        end
        total++;
        for (int k = 0; k < 2; k++) begin
            step(16'h0400, 3'd0, 1'b1, 5'b00001, rdy);
            if (rdy !== 1'b0 || bus.out_valid !== 5'b01000 || bus.out_data !== 16'h031F || bus.cur_dest !== 3'd3) begin
                bad++;
                $display("FAIL last_hold k=%0d rdy=%b got %b/%h dest=%0d exp 0 01000/031f 3", k, rdy,
                         bus.out_valid, bus.out_data, bus.cur_dest);
            end
            total++;
        end
        step(16'h0400, 3'd0, 1'b1, 5'b01000, rdy);
        if (rdy !== 1'b1 || bus.out_valid !== 5'b00001 || bus.out_data !== 16'h0400 || bus.cur_dest !== 3'd0) begin
            bad++;
            $display("FAIL last_switch rdy=%b got %b/%h dest=%0d exp 1 00001/0400 0", rdy, bus.out_valid,
                     bus.out_data, bus.cur_dest);
        end
        total++;
        for (int i = 1; i < 32; i++) begin
            step(16'h0400 + 16'(i), 3'd3, 1'b1, 5'b11111, rdy);
            if (bus.out_valid !== 5'b00001 || bus.out_data !== 16'h0400 + 16'(i)) begin
                bad++;
                $display("FAIL last_f2 i=%0d got %b/%h", i, bus.out_valid, bus.out_data);
            end
            total++;
        end
        idle();
    endtask

    task automatic test_illegal_dest();
        logic rdy;
        for (int i = 0; i < 32; i++) begin
            step(16'h0500 + 16'(i), 3'd6, 1'b1, 5'b00000, rdy);
            if (rdy !== 1'b1 || bus.out_valid !== 5'b0 || bus.frame_done !== (i == 31)) begin
                bad++;
                $display("FAIL illegal i=%0d rdy=%b valid=%b fd=%b", i, rdy, bus.out_valid, bus.frame_done);
            end
            total++;
            if (i == 0 && (bus.err !== ERR_EXP || bus.cur_dest !== 3'd6)) begin
                bad++;
                $display("FAIL illegal_err err=%b dest=%0d exp %b/6", bus.err, bus.cur_dest, ERR_EXP);
            end
            total++;
        end
        for (int i = 0; i < 32; i++) begin
            step(16'h0510 + 16'(i), 3'd1, 1'b1, 5'b11111, rdy);
            if (bus.out_valid !== 5'b00010 || bus.out_data !== 16'h0510 + 16'(i)) begin
                bad++;
                $display("FAIL illegal_next i=%0d got %b/%h", i, bus.out_valid, bus.out_data);
            end
            total++;
        end
        if (bus.err !== ERR_EXP) begin
            bad++;
            $display("FAIL err_sticky got %b exp %b", bus.err, ERR_EXP);
        end
        total++;
        idle();
    endtask

    task automatic test_reset_midframe();
        logic rdy;
        for (int i = 0; i < 10; i++) step(16'h0700 + 16'(i), 3'd2, 1'b1, 5'b11111, rdy);
        if (bus.out_valid !== 5'b00100 || bus.out_data !== 16'h0709) begin
            bad++;
            $display("FAIL mid_full got %b/%h exp 00100/0709", bus.out_valid, bus.out_data);
        end
        total++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dest_sel = 3'd0;
        rst = 1'b1;
        #1;
        if ({bus.out_data, bus.out_valid, bus.in_ready, bus.cur_dest, bus.frame_done, bus.err} !==
            {16'h0, 5'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset got data=%h valid=%b rdy=%b dest=%0d fd=%b err=%b", bus.out_data,
                     bus.out_valid, bus.in_ready, bus.cur_dest, bus.frame_done, bus.err);
        end
        total++;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step(16'h0600 + 16'(i), (i == 0) ? 3'd4 : 3'd2, 1'b1, 5'b11111, rdy);
            if (bus.out_valid !== 5'b10000 || bus.out_data !== 16'h0600 + 16'(i) ||
                bus.cur_dest !== 3'd4 || bus.frame_done !== (i == 31)) begin
                bad++;
                $display("FAIL mid_restart i=%0d got %b/%h dest=%0d fd=%b", i, bus.out_valid, bus.out_data,
                         bus.cur_dest, bus.frame_done);
            end
            total++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_dest_toggle();
        test_backpressure();
        test_stalled_last();
        test_illegal_dest();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft32_demux1x5.md
# fft32_demux1x5

Frame-based 1-to-5 stream distributor for the 32-point FFT datapath, the write-side counterpart of the 5-input stage selector. Accepts one DATA_WIDTH sample per handshake and routes each 32-sample frame to one of five destinations (one per radix-2 stage buffer), chosen once per frame. It sits between the sample source / stage write-back bus and the five stage buffers and provides a one-entry registered output stage with per-destination backpressure.

## Interface
- DATA_WIDTH, 16, sample width in bits
- SEL_WIDTH, 3, destination selector width
- FRAME_LEN, 32, samples per frame (power of two)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATA_WIDTH  sample
- in_valid  input  1  sample present
- in_ready  output  1  sample accepted when in_valid && in_ready
- dest_sel  input  SEL_WIDTH  destination for the frame; sampled only on the first sample of a frame
- out_data  output  DATA_WIDTH  shared data bus to all destinations
- out_valid  output  5  one-hot; bit k = out_data valid for destination k
- out_ready  input  5  per-destination ready
- cur_dest  output  SEL_WIDTH  destination latched for the current frame
- frame_done  output  1  one-cycle pulse after the last sample of a frame is accepted
- err  output  1  sticky illegal-destination flag (see Configuration)

## Operation
- Sample counter cnt (log2(FRAME_LEN) bits) counts accepted input samples, wraps FRAME_LEN-1 -> 0.
- On acceptance with cnt==0: cur_dest <= dest_sel. cur_dest constant for the rest of the frame; dest_sel changes mid-frame are ignored.
- Output register holds {data, tag}. Tag = destination of the held sample, so a frame's last sample is delivered to its own destination even after cur_dest changes.
- out_valid = one-hot(tag) when register full, else 0.
- Drain: register empties when out_valid[tag] && out_ready[tag]. out_ready bits of non-selected destinations are ignored.
- in_ready = !full || out_ready[tag], i.e. accept when empty or draining this cycle; simultaneous drain+accept reloads the register, out_valid stays high.
- Illegal destination (selector value >= 5, for the frame in progress — dest_sel on first sample, cur_dest thereafter): samples accepted with in_ready=1 regardless of output state, not loaded, discarded; counter still advances and frame_done still fires.
- frame_done registered: high the cycle after acceptance with cnt==FRAME_LEN-1.

## Timing
- Reset values: out_data=0, out_valid=0, in_ready=1, cur_dest=0, cnt=0, frame_done=0, err=0; register empty.
- Latency: sample accepted on edge N appears on out_data/out_valid after edge N; throughput 1 sample/cycle with out_ready held high.
- out_data/out_valid must stay stable while out_valid[tag]=1 and out_ready[tag]=0.
- Reset mid-frame: held sample dropped, counter restarts, next accepted sample starts a new frame.

## Configuration
- FFT32_DEMUX_ERR_EN defined: err sets on the cycle after a frame starts with dest_sel >= 5; sticky until rst.
- Not defined: err tied to 0; discard behaviour unchanged.

## Structure
- Shared package fft32_pkg: FRAME_LEN=32, NUM_DEST=5, SEL_WIDTH=3, destination encodings DEST_STAGE0..DEST_STAGE4 = 0..4.
- One natural sub-module: fft32_pipe_reg (one-entry valid/ready register carrying data+tag); counter and destination latch stay in the top.

## Test plan
- Reset, then stream 0x0000..0x001F with dest_sel=2, all out_ready=1 -> out_valid=5'b00100 for 32 consecutive cycles, data in order, cur_dest=2, frame_done pulses once one cycle after the 32nd sample is accepted (same edge as the last sample appears on out_data).
- Two frames dest_sel=0 then 4, toggle dest_sel every cycle mid-frame -> first 32 samples on bit 0, next 32 on bit 4; mid-frame changes ignored.
- Frame to dest 1 with out_ready[1] low for 3 cycles at sample 5 -> in_ready=0, out_data holds sample 5 stable 3 cycles, no loss or duplication; out_ready[3] pulsed meanwhile has no effect.
- Last sample of a frame (dest 3) stalled while next frame to dest 0 is presented -> last sample delivered on bit 3, then the new frame's first sample on bit 0.
- Frame with dest_sel=6 -> in_ready=1 for all 32 samples, out_valid=0 throughout, frame_done pulses; err=1 with FFT32_DEMUX_ERR_EN, 0 without; next frame with dest_sel=1 delivers normally.
- Assert rst for 1 cycle at sample 10 with output full -> all outputs at reset values immediately; following frame starts at cnt=0 with fresh dest_sel.
